// File: rtl/affine_transform_pipe.sv
// -----------------------------------------------------------------------------
// affine_transform_pipe
//
// Purpose:
//   Multi-lane, elastic, pipelined version of the S-box affine stage. Every
//   beat carries LANES independent bytes and a 2-bit mode that selects one of
//   four transforms: forward affine (encrypt), inverse affine (decrypt),
//   pass-through, or zero. The transform is computed combinationally on the
//   input and captured in stage 0. Later stages only carry the beat forward.
//   Both sides use a valid/ready handshake. The ready chain is combinational,
//   so a full pipeline still moves one beat per cycle with no bubbles.
//
// Parameters:
//   LANES  - byte lanes per beat (1..16)
//   STAGES - register stages from input to output (1..4)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   input beat present
//   in_ready   out  input beat is accepted this cycle
//   in_mode    in   00 forward, 01 inverse, 10 pass-through, 11 zero
//   in_data    in   lane k occupies bits [8k+7:8k]
//   out_valid  out  output beat present (last stage valid)
//   out_ready  in   downstream accepts the output beat
//   out_data   out  transformed lanes
//   out_mode   out  mode that travelled with the beat
//   out_parity out  (AFFINE_TRANSFORM_PIPE_PARITY_EN only) per-lane XOR parity
//   busy       out  at least one stage holds a valid beat
//
// Optional feature:
//   Define AFFINE_TRANSFORM_PIPE_PARITY_EN to add out_parity. Each bit is the
//   parity of one output lane. Parity is computed from the stage-0 result and
//   pipelined next to the data. When the macro is undefined, the port and its
//   registers are not built.
// -----------------------------------------------------------------------------
module affine_transform_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [1:0]           out_mode,
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  output logic [LANES-1:0]     out_parity,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_INV  = 2'b01,
    MODE_PASS = 2'b10,
    MODE_ZERO = 2'b11
  } mode_e;

  // Single-byte transform. Bit indices wrap modulo 8, so every output bit is
  // an XOR of a rotated view of the input byte.
  function automatic logic [7:0] affineByte(input logic [7:0] b, input logic [1:0] mode);
    logic [7:0] r;
    r = '0;
    case (mode_e'(mode))
      MODE_FWD: begin
        for (int i = 0; i < 8; i++) begin
          r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        end
        r = r ^ 8'h63;
      end
      MODE_INV: begin
        for (int i = 0; i < 8; i++) begin
          r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        r = r ^ 8'h05;
      end
      MODE_PASS: r = b;
      default:   r = 8'h00;
    endcase
    return r;
  endfunction

  // Pipeline state: one valid flag, one data word and one mode per stage.
  logic [STAGES-1:0]  valid_q, valid_d;
  logic [STAGES-1:0]  advance;
  logic [8*LANES-1:0] data_q [STAGES];
  logic [8*LANES-1:0] data_d [STAGES];
  logic [1:0]         mode_q [STAGES];
  logic [1:0]         mode_d [STAGES];
  logic [8*LANES-1:0] stage0Data;

`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  logic [LANES-1:0]   parity_q [STAGES];
  logic [LANES-1:0]   parity_d [STAGES];
  logic [LANES-1:0]   stage0Parity;
`endif

  // Transform all lanes of the incoming beat. Lanes never mix.
  always_comb begin
    stage0Data = '0;
    for (int k = 0; k < LANES; k++) begin
      stage0Data[8*k +: 8] = affineByte(in_data[8*k +: 8], in_mode);
    end
  end

`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  always_comb begin
    stage0Parity = '0;
    for (int k = 0; k < LANES; k++) begin
      stage0Parity[k] = ^stage0Data[8*k +: 8];
    end
  end
`endif

  // The advance chain runs from the output back to the input. A stage may
  // take a new beat when it is empty, or when the stage ahead of it advances
  // at the same time. A running variable carries the chain, so no signal
  // feeds back into itself.
  always_comb begin
    logic chainAdv;
    advance  = '0;
    chainAdv = ~valid_q[STAGES-1] | out_ready;
    advance[STAGES-1] = chainAdv;
    for (int s = STAGES - 2; s >= 0; s--) begin
      chainAdv   = ~valid_q[s] | chainAdv;
      advance[s] = chainAdv;
    end
  end

  // Next-state logic. A stage that advances takes the valid flag of the stage
  // behind it. Its payload registers load only when a real beat arrives, so
  // bubbles do not toggle the data path.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
    parity_d = parity_q;
`endif
    if (advance[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = stage0Data;
        mode_d[0] = in_mode;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
        parity_d[0] = stage0Parity;
`endif
      end
    end
    for (int s = 1; s < STAGES; s++) begin
      if (advance[s]) begin
        valid_d[s] = valid_q[s-1];
        if (valid_q[s-1]) begin
          data_d[s] = data_q[s-1];
          mode_d[s] = mode_q[s-1];
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
          parity_d[s] = parity_q[s-1];
`endif
        end
      end
    end
  end

  // Stage registers. Reset clears everything at once, which drops any beats
  // in flight and forces the outputs to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        mode_q[s] <= '0;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
        parity_q[s] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign busy      = |valid_q;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  assign out_parity = parity_q[STAGES-1];
`endif

endmodule

// File: tb/tb_affine_transform_pipe.sv
// -----------------------------------------------------------------------------
// tb_affine_transform_pipe
//
// Purpose:
//   Directed self-checking bench for affine_transform_pipe with LANES=4 and
//   STAGES=2. It covers:
//     - reset state
//     - all four modes with hand-computed vectors
//     - backpressure fill and drain
//     - back-to-back streaming against a rotate-based reference
//     - asynchronous reset while beats are in flight
//   When AFFINE_TRANSFORM_PIPE_PARITY_EN is defined, it also checks the lane
//   parity.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_affine_transform_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int W      = 8 * LANES;
  localparam int NSTREAM = 100;

  // Directed vectors. Expected outputs were worked out by hand from the
  // bit equations.
  localparam logic [31:0] DIR_IN   [6] = '{32'hCA010000, 32'hED7C6363, 32'h12345678,
                                           32'hA5A5A5A5, 32'h00000000, 32'h01010101};
  localparam logic [1:0]  DIR_MODE [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
  localparam logic [31:0] DIR_EXP  [6] = '{32'hED7C6363, 32'hCA010000, 32'h12345678,
                                           32'h00000000, 32'h63636363, 32'h7C7C7C7C};
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  localparam logic [3:0]  DIR_PAR  [6] = '{4'b0100, 4'b0100, 4'b0100,
                                           4'b0000, 4'b0000, 4'b1111};
`endif
  localparam logic [31:0] BP_DATA  [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic [1:0]   inMode;
  logic [W-1:0] inData;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outData;
  logic [1:0]   outMode;
  logic         busy;
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
  logic [LANES-1:0] outParity;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [W-1:0] sData [NSTREAM];
  logic [1:0]   sMode [NSTREAM];

  // Free-running clock. The DUT registers on the rising edge.
  always #5 clk = ~clk;

  affine_transform_pipe #(
    .LANES  (LANES),
    .STAGES (STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_mode    (inMode),
    .in_data    (inData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_mode   (outMode),
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
    .out_parity (outParity),
`endif
    .busy       (busy)
  );

  // Compares one observed value with its expected value and counts the check.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the input side of the handshake.
  task automatic applyStimulus(input logic valid, input logic [W-1:0] data,
                               input logic [1:0] mode);
    inValid = valid;
    inData  = data;
    inMode  = mode;
  endtask

  // Reference model. It is written as XORs of byte rotations, a different
  // formulation from the per-bit index equations.
  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] refByte(input logic [7:0] b, input logic [1:0] mode);
    case (mode)
      2'b00:   return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      2'b01:   return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
      2'b10:   return b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [W-1:0] refWord(input logic [W-1:0] d, input logic [1:0] mode);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[8*k +: 8] = refByte(d[8*k +: 8], mode);
    return r;
  endfunction

  // Main sequence. Inputs are driven on the falling edge and outputs are
  // sampled there too, half a cycle away from the active edge.
  initial begin
    int idx;
    int seenValid;

    for (int n = 0; n < NSTREAM; n++) begin
      sData[n] = W'($urandom);
      sMode[n] = 2'($urandom_range(0, 3));
    end

    // Reset state
    reset    = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, '0, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", 64'(outValid), 64'd0);
    checkOutput("rstBusy",     64'(busy),     64'd0);
    checkOutput("rstOutData",  64'(outData),  64'd0);
    checkOutput("rstOutMode",  64'(outMode),  64'd0);
    checkOutput("rstInReady",  64'(inReady),  64'd1);
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
    checkOutput("rstParity",   64'(outParity), 64'd0);
`endif
    reset = 1'b0;

    // Directed single beats, one per mode
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, DIR_IN[i], DIR_MODE[i]);
      checkOutput("dirInReady", 64'(inReady), 64'd1);
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00);
      checkOutput("dirEarlyValid", 64'(outValid), 64'd0);
      @(negedge clk);
      checkOutput("dirOutValid", 64'(outValid), 64'd1);
      checkOutput("dirOutData",  64'(outData),  64'(DIR_EXP[i]));
      checkOutput("dirOutMode",  64'(outMode),  64'(DIR_MODE[i]));
`ifdef AFFINE_TRANSFORM_PIPE_PARITY_EN
      checkOutput("dirParity",   64'(outParity), 64'(DIR_PAR[i]));
`endif
    end

    // Backpressure: offer three beats while the output is stalled
    @(negedge clk);
    checkOutput("bpStartEmpty", 64'(busy), 64'd0);
    outReady = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, BP_DATA[(idx < 3) ? idx : 2], 2'b10);
      if (inReady) idx++;
    end
    checkOutput("bpAccepted",  64'(idx),      64'd2);
    checkOutput("bpInReady",   64'(inReady),  64'd0);
    checkOutput("bpOutValid",  64'(outValid), 64'd1);
    checkOutput("bpHoldData",  64'(outData),  64'(BP_DATA[0]));
    @(negedge clk);
    checkOutput("bpHoldData2", 64'(outData),  64'(BP_DATA[0]));
    checkOutput("bpHoldMode",  64'(outMode),  64'd2);
    outReady = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, '0, 2'b00);
    checkOutput("bpDrain1Valid", 64'(outValid), 64'd1);
    checkOutput("bpDrain1Data",  64'(outData),  64'(BP_DATA[1]));
    @(negedge clk);
    checkOutput("bpDrain2Valid", 64'(outValid), 64'd1);
    checkOutput("bpDrain2Data",  64'(outData),  64'(BP_DATA[2]));
    @(negedge clk);
    checkOutput("bpDrainedValid", 64'(outValid), 64'd0);
    checkOutput("bpDrainedBusy",  64'(busy),     64'd0);

    // Streaming at full rate. The beat driven at falling edge n must appear
    // at falling edge n+STAGES.
    for (int n = 0; n < NSTREAM + STAGES; n++) begin
      @(negedge clk);
      if (n >= STAGES) begin
        checkOutput("strValid", 64'(outValid), 64'd1);
        checkOutput("strData",  64'(outData),  64'(refWord(sData[n-STAGES], sMode[n-STAGES])));
        checkOutput("strMode",  64'(outMode),  64'(sMode[n-STAGES]));
      end
      if (n < NSTREAM) begin
        applyStimulus(1'b1, sData[n], sMode[n]);
        checkOutput("strInReady", 64'(inReady), 64'd1);
      end else begin
        applyStimulus(1'b0, '0, 2'b00);
      end
    end
    @(negedge clk);
    checkOutput("strEndValid", 64'(outValid), 64'd0);
    checkOutput("strEndBusy",  64'(busy),     64'd0);

    // Asynchronous reset with two beats in flight
    outReady = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'hDEADBEEF, 2'b10);
    @(negedge clk);
    applyStimulus(1'b1, 32'hCAFEF00D, 2'b10);
    @(negedge clk);
    applyStimulus(1'b0, '0, 2'b00);
    checkOutput("midOutValid", 64'(outValid), 64'd1);
    checkOutput("midOutData",  64'(outData),  64'hDEADBEEF);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arstOutValid", 64'(outValid), 64'd0);
    checkOutput("arstBusy",     64'(busy),     64'd0);
    checkOutput("arstOutData",  64'(outData),  64'd0);
    checkOutput("arstInReady",  64'(inReady),  64'd1);
    @(negedge clk);
    reset    = 1'b0;
    outReady = 1'b1;
    seenValid = 0;
    repeat (4) begin
      @(negedge clk);
      if (outValid) seenValid++;
    end
    checkOutput("arstNoStale", 64'(seenValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
